// File: rtl/proc_ctrl_pkg.sv
// Shared encodings for the 8-bit processor control sequencer.
package proc_ctrl_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_LD   = 4'h2;
   localparam logic [3:0] OP_ST   = 4'h3;
   localparam logic [3:0] OP_JMP  = 4'h4;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [3:0] {
      IDLE, F0, F0G, F1, F1G, X_RFW, X_MRD, X_RRD, X_MWR, X_G1, X_G, HALTED
   } state_t;

   // True for every opcode the ISA defines; anything else runs as a NOP.
   function automatic logic op_legal(input logic [3:0] op);
      return op inside {OP_NOP, OP_LDI, OP_LD, OP_ST, OP_JMP, OP_HALT};
   endfunction

endpackage

// File: rtl/proc_control_fsm.sv
// Fetch/decode/execute sequencer for the 8-bit processor. Every output is a
// flop loaded from the next state, so strobes line up exactly with states.
// Address, data and mux select are loaded in the gap cycle ahead of the
// strobe that uses them, since the storage blocks act on the strobe edge.
module proc_control_fsm
   import proc_ctrl_pkg::*;
#(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       mem_we,
   output logic       mem_re,
   input  logic [7:0] mem_rdata,
   output logic [3:0] rf_addr,
   output logic       rf_we,
   output logic       rf_re,
   input  logic [7:0] rf_rdata,
   output logic       rf_wsel,
   output logic [7:0] operand,
   output logic [7:0] pc,
   output logic       busy,
   output logic       halted,
   output logic       illegal
);

   state_t     r_state, w_next;
   logic [7:0] r_pc, r_ir, r_operand, r_mem_addr, r_mem_wdata;
   logic [3:0] r_rf_addr;
   logic       r_mem_we, r_mem_re, r_rf_we, r_rf_re, r_rf_wsel;
   logic       r_busy, r_halted, r_illegal;
   logic [3:0] w_op;

   assign w_op = r_ir[7:4];

   // Next-state sequencing; decode happens in F1G once both bytes are held.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:   if (start) w_next = F0;
         F0:     w_next = F0G;
         F0G:    w_next = F1;
         F1:     w_next = F1G;
         F1G: begin
            case (w_op)
               OP_LDI:  w_next = X_RFW;
               OP_LD:   w_next = X_MRD;
               OP_ST:   w_next = X_RRD;
               OP_HALT: w_next = HALTED;
               default: w_next = F0;
            endcase
         end
         X_MRD:  w_next = X_G1;
         X_RRD:  w_next = X_G1;
         X_G1:   w_next = (w_op == OP_LD) ? X_RFW : X_MWR;
         X_RFW:  w_next = X_G;
         X_MWR:  w_next = X_G;
         X_G:    w_next = F0;
         HALTED: w_next = HALTED;
         default: w_next = IDLE;
      endcase
   end

   // State, datapath registers and registered Moore outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_pc        <= RESET_PC;
         r_ir        <= 8'h00;
         r_operand   <= 8'h00;
         r_mem_addr  <= 8'h00;
         r_mem_wdata <= 8'h00;
         r_rf_addr   <= 4'h0;
         r_mem_we    <= 1'b0;
         r_mem_re    <= 1'b0;
         r_rf_we     <= 1'b0;
         r_rf_re     <= 1'b0;
         r_rf_wsel   <= 1'b0;
         r_busy      <= 1'b0;
         r_halted    <= 1'b0;
         r_illegal   <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_mem_re <= (w_next == F0) || (w_next == F1) || (w_next == X_MRD);
         r_mem_we <= (w_next == X_MWR);
         r_rf_re  <= (w_next == X_RRD);
         r_rf_we  <= (w_next == X_RFW);
         r_busy   <= !((w_next == IDLE) || (w_next == HALTED));
         r_halted <= (w_next == HALTED);
         case (r_state)
            IDLE: r_mem_addr <= r_pc;
            F0: begin
               r_ir       <= mem_rdata;
               r_mem_addr <= r_pc + 8'd1;
            end
            F0G: begin
               r_rf_addr <= r_ir[3:0];
               r_rf_wsel <= (w_op == OP_LD);
            end
            F1: begin
               r_operand <= mem_rdata;
               r_pc      <= r_pc + 8'd2;
               // Next memory access is either the data byte or the next fetch.
               if (w_op inside {OP_JMP, OP_LD, OP_ST})
                  r_mem_addr <= mem_rdata;
               else
                  r_mem_addr <= r_pc + 8'd2;
            end
            F1G: begin
               if (w_op == OP_JMP)  r_pc      <= r_operand;
               if (!op_legal(w_op)) r_illegal <= 1'b1;
            end
            X_RRD: r_mem_wdata <= rf_rdata;
            X_G1:  if (w_op == OP_LD) r_mem_addr <= r_pc;
            X_MWR: r_mem_addr <= r_pc;
            default: ;
         endcase
      end
   end

   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_we    = r_mem_we;
   assign mem_re    = r_mem_re;
   assign rf_addr   = r_rf_addr;
   assign rf_we     = r_rf_we;
   assign rf_re     = r_rf_re;
   assign rf_wsel   = r_rf_wsel;
   assign operand   = r_operand;
   assign pc        = r_pc;
   assign busy      = r_busy;
   assign halted    = r_halted;
   assign illegal   = r_illegal;

endmodule

// File: tb/tb_proc_control_fsm.sv
// Bench for proc_control_fsm: memory and register-file device models, a
// strobe logger, and an ISA-level reference interpreter.
module tb_proc_control_fsm;

   localparam logic [1:0] K_MRE = 2'd0, K_MWE = 2'd1, K_RRE = 2'd2, K_RWE = 2'd3;

   typedef struct packed {
      int unsigned c;
      logic [1:0]  k;
      logic [7:0]  a;
      logic [7:0]  d;
   } ev_t;

   logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [7:0] mem_addr, mem_wdata, mem_rdata, rf_rdata, operand, pc;
   logic [3:0] rf_addr;
   logic       mem_we, mem_re, rf_we, rf_re, rf_wsel, busy, halted, illegal;

   proc_control_fsm #(.RESET_PC(8'h00)) dut (
      .clk(clk), .reset(reset), .start(start),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .rf_addr(rf_addr), .rf_we(rf_we), .rf_re(rf_re),
      .rf_rdata(rf_rdata), .rf_wsel(rf_wsel), .operand(operand), .pc(pc),
      .busy(busy), .halted(halted), .illegal(illegal)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] img_mem [256];
   logic [7:0] img_rf  [16];
   logic [7:0] dmem    [256];
   logic [7:0] drf     [16];
   bit         ld_req = 1'b0;

   ev_t lg[$];
   int  viol = 0;
   logic       p_mre = 0, p_mwe = 0, p_rre = 0, p_rwe = 0, p_wsel = 0;
   logic [7:0] p_ma = 0, p_wd = 0;
   logic [3:0] p_ra = 0;

   // Devices act mid-cycle on strobes; the logger records every strobe and
   // counts protocol breaches (overlap, repeat, address/data not set up).
   always @(negedge clk) begin
      if (ld_req) begin
         dmem = img_mem;
         drf  = img_rf;
         mem_rdata <= 8'h00;
         rf_rdata  <= 8'h00;
      end else begin
         if (mem_re) mem_rdata <= dmem[mem_addr];
         if (mem_we) dmem[mem_addr] = mem_wdata;
         if (rf_re)  rf_rdata <= drf[rf_addr];
         if (rf_we)  drf[rf_addr] = rf_wsel ? mem_rdata : operand;
      end
      if ((int'(mem_re) + int'(mem_we) + int'(rf_re) + int'(rf_we)) > 1) viol++;
      if ((mem_re && p_mre) || (mem_we && p_mwe) || (rf_re && p_rre) || (rf_we && p_rwe)) viol++;
      if ((mem_re || mem_we) && mem_addr !== p_ma) viol++;
      if (mem_we && mem_wdata !== p_wd) viol++;
      if ((rf_re || rf_we) && rf_addr !== p_ra) viol++;
      if (rf_we && rf_wsel !== p_wsel) viol++;
      if (mem_re) lg.push_back('{c: cyc, k: K_MRE, a: mem_addr, d: 8'h00});
      if (mem_we) lg.push_back('{c: cyc, k: K_MWE, a: mem_addr, d: mem_wdata});
      if (rf_re)  lg.push_back('{c: cyc, k: K_RRE, a: {4'h0, rf_addr}, d: 8'h00});
      if (rf_we)  lg.push_back('{c: cyc, k: K_RWE, a: {4'h0, rf_addr}, d: rf_wsel ? mem_rdata : operand});
      p_mre = mem_re; p_mwe = mem_we; p_rre = rf_re; p_rwe = rf_we;
      p_ma = mem_addr; p_wd = mem_wdata; p_ra = rf_addr; p_wsel = rf_wsel;
   end

   // ---------------- reference model ----------------
   logic [7:0]  m_mem [256];
   logic [7:0]  m_rf  [16];
   logic [7:0]  m_pc;
   bit          m_ill;
   int unsigned m_halt_cyc;
   ev_t         ex[$];

   int n_chk = 0, n_fail = 0;

   task automatic push_ex(input int unsigned c, input logic [1:0] k,
                          input logic [7:0] a, input logic [7:0] d);
      ex.push_back('{c: c, k: k, a: a, d: d});
   endtask

   // Instruction-level interpreter; each instruction starts at cycle s with
   // its F0 fetch and occupies a fixed number of cycles.
   task automatic model_run(input int unsigned s0);
      int unsigned s = s0;
      logic [7:0] b0, b1, a1;
      logic [7:0] r;
      m_pc = 8'h00;
      m_halt_cyc = 0;
      for (int step = 0; step < 300; step++) begin
         a1 = m_pc + 8'd1;
         b0 = m_mem[m_pc];
         b1 = m_mem[a1];
         r  = {4'h0, b0[3:0]};
         push_ex(s, K_MRE, m_pc, 8'h00);
         push_ex(s + 2, K_MRE, a1, 8'h00);
         m_pc = m_pc + 8'd2;
         case (b0[7:4])
            4'h0: s += 4;
            4'h1: begin push_ex(s + 4, K_RWE, r, b1); m_rf[b0[3:0]] = b1; s += 6; end
            4'h2: begin
               push_ex(s + 4, K_MRE, b1, 8'h00);
               push_ex(s + 6, K_RWE, r, m_mem[b1]);
               m_rf[b0[3:0]] = m_mem[b1];
               s += 8;
            end
            4'h3: begin
               push_ex(s + 4, K_RRE, r, 8'h00);
               push_ex(s + 6, K_MWE, b1, m_rf[b0[3:0]]);
               m_mem[b1] = m_rf[b0[3:0]];
               s += 8;
            end
            4'h4: begin m_pc = b1; s += 4; end
            4'hF: begin m_halt_cyc = s + 4; break; end
            default: begin m_ill = 1'b1; s += 4; end
         endcase
      end
   endtask

   task automatic load_and_start(output int unsigned s0, output int base);
      reset = 1'b1; ld_req = 1'b1;
      repeat (2) @(negedge clk);
      ld_req = 1'b0; reset = 1'b0;
      base = lg.size();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      s0 = cyc;
   endtask

   // Runs the loaded image to HALT and checks timing, strobes and end state.
   task automatic run_prog(input string nm, input int budget);
      int unsigned s0, hc;
      int base, nexp, ngot, bad;
      int v0;
      bit seen;
      m_mem = img_mem; m_rf = img_rf; m_ill = 1'b0; ex.delete();
      v0 = viol;
      load_and_start(s0, base);
      model_run(s0);
      seen = 1'b0; hc = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (halted) begin seen = 1'b1; hc = cyc; end
      end
      @(negedge clk);
      n_chk++;
      if (!seen || hc !== m_halt_cyc) begin
         n_fail++;
         $display("FAIL %s halt_cycle: seen=%0d got %0d expected %0d", nm, seen, hc - s0, m_halt_cyc - s0);
      end
      n_chk++;
      if (pc !== m_pc) begin n_fail++; $display("FAIL %s pc: got %h expected %h", nm, pc, m_pc); end
      n_chk++;
      if (illegal !== m_ill) begin n_fail++; $display("FAIL %s illegal: got %b expected %b", nm, illegal, m_ill); end
      n_chk++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_after_halt: got %b expected 0", nm, busy); end
      ngot = lg.size() - base; nexp = ex.size();
      n_chk++;
      if (ngot !== nexp) begin n_fail++; $display("FAIL %s strobe_count: got %0d expected %0d", nm, ngot, nexp); end
      for (int i = 0; i < nexp && i < ngot; i++) begin
         n_chk++;
         if (lg[base + i] !== ex[i]) begin
            n_fail++;
            $display("FAIL %s strobe%0d: got c=%0d k=%0d a=%h d=%h expected c=%0d k=%0d a=%h d=%h", nm, i,
                     lg[base+i].c - s0, lg[base+i].k, lg[base+i].a, lg[base+i].d,
                     ex[i].c - s0, ex[i].k, ex[i].a, ex[i].d);
         end
      end
      for (int i = 0; i < 16; i++) begin
         n_chk++;
         if (drf[i] !== m_rf[i]) begin n_fail++; $display("FAIL %s rf[%0d]: got %h expected %h", nm, i, drf[i], m_rf[i]); end
      end
      bad = 0;
      for (int i = 0; i < 256; i++) if (dmem[i] !== m_mem[i]) bad++;
      n_chk++;
      if (bad != 0) begin n_fail++; $display("FAIL %s mem_image: %0d bytes differ, expected 0", nm, bad); end
      n_chk++;
      if (viol != v0) begin n_fail++; $display("FAIL %s strobe_protocol: %0d breaches, expected 0", nm, viol - v0); end
   endtask

   task automatic clear_images();
      for (int i = 0; i < 256; i++) img_mem[i] = 8'h00;
      for (int i = 0; i < 16; i++)  img_rf[i]  = 8'h00;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_chk++;
      if ({mem_re, mem_we, rf_re, rf_we} !== 4'b0) begin n_fail++; $display("FAIL reset strobes: got %b expected 0000", {mem_re, mem_we, rf_re, rf_we}); end
      n_chk++;
      if ({busy, halted, illegal, rf_wsel} !== 4'b0) begin n_fail++; $display("FAIL reset flags: got %b expected 0000", {busy, halted, illegal, rf_wsel}); end
      n_chk++;
      if (pc !== 8'h00) begin n_fail++; $display("FAIL reset pc: got %h expected 00", pc); end
      n_chk++;
      if ({mem_addr, mem_wdata, operand, rf_addr} !== 28'h0) begin
         n_fail++; $display("FAIL reset regs: got %h %h %h %h expected zero", mem_addr, mem_wdata, operand, rf_addr);
      end
   endtask

   task automatic test_ldi_halt();
      int unsigned t;
      clear_images();
      img_mem[0] = 8'h10; img_mem[1] = 8'h2A; img_mem[2] = 8'hF0; img_mem[3] = 8'h00;
      run_prog("ldi_halt", 40);
      n_chk++;
      if (pc !== 8'h04 || halted !== 1'b1) begin n_fail++; $display("FAIL ldi_halt final: got pc=%h halted=%b expected 04 1", pc, halted); end
      n_chk++;
      if (drf[0] !== 8'h2A) begin n_fail++; $display("FAIL ldi_halt r0: got %h expected 2a", drf[0]); end
      // start must be ignored once halted
      t = cyc;
      start = 1'b1; @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      n_chk++;
      if (halted !== 1'b1 || busy !== 1'b0 || pc !== 8'h04 || mem_re !== 1'b0) begin
         n_fail++; $display("FAIL halt_ignores_start: got halted=%b busy=%b pc=%h after %0d cycles expected 1 0 04", halted, busy, pc, cyc - t);
      end
   endtask

   task automatic test_ld();
      clear_images();
      img_mem[0] = 8'h23; img_mem[1] = 8'h80; img_mem[2] = 8'hF0; img_mem[8'h80] = 8'h5C;
      run_prog("ld", 40);
      n_chk++;
      if (drf[3] !== 8'h5C) begin n_fail++; $display("FAIL ld r3: got %h expected 5c", drf[3]); end
   endtask

   task automatic test_st();
      clear_images();
      img_rf[7] = 8'hA5;
      img_mem[0] = 8'h37; img_mem[1] = 8'h40; img_mem[2] = 8'hF0;
      run_prog("st", 40);
      n_chk++;
      if (dmem[8'h40] !== 8'hA5) begin n_fail++; $display("FAIL st mem40: got %h expected a5", dmem[8'h40]); end
   endtask

   task automatic test_wrap();
      clear_images();
      img_mem[0] = 8'h40; img_mem[1] = 8'hFF; img_mem[2] = 8'h00; img_mem[8'hFF] = 8'h00;
      run_prog("wrap", 60);
      n_chk++;
      if (pc !== 8'h03) begin n_fail++; $display("FAIL wrap pc: got %h expected 03", pc); end
   endtask

   task automatic test_illegal();
      clear_images();
      img_mem[0] = 8'h95; img_mem[1] = 8'h11; img_mem[2] = 8'hF0;
      run_prog("illegal", 40);
      n_chk++;
      if (illegal !== 1'b1 || pc !== 8'h04) begin n_fail++; $display("FAIL illegal sticky: got ill=%b pc=%h expected 1 04", illegal, pc); end
   endtask

   task automatic test_reset_mid_st();
      int unsigned s0;
      int base, nmwe;
      clear_images();
      img_rf[7] = 8'hA5;
      img_mem[0] = 8'h37; img_mem[1] = 8'h40; img_mem[2] = 8'hF0;
      load_and_start(s0, base);
      repeat (5) @(negedge clk);   // now in the cycle just before the write strobe
      reset = 1'b1;
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || pc !== 8'h00 || mem_we !== 1'b0 || halted !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid_st state: got busy=%b pc=%h we=%b halted=%b expected 0 00 0 0", busy, pc, mem_we, halted);
      end
      n_chk++;
      if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_mid_st illegal_cleared: got %b expected 0", illegal); end
      @(negedge clk); reset = 1'b0;
      repeat (8) @(negedge clk);
      nmwe = 0;
      for (int i = base; i < lg.size(); i++) if (lg[i].k == K_MWE) nmwe++;
      n_chk++;
      if (nmwe != 0 || lg.size() - base != 3) begin
         n_fail++; $display("FAIL reset_mid_st strobes: got %0d total %0d writes expected 3 total 0 writes", lg.size() - base, nmwe);
      end
      n_chk++;
      if (dmem[8'h40] !== 8'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_st mem40: got %h busy=%b expected 00 0", dmem[8'h40], busy); end
   endtask

   task automatic test_random();
      int n, sel, j;
      logic [3:0] ops [6];
      ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h9};
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < 256; i++) img_mem[i] = (i >= 128) ? 8'($urandom) : 8'h00;
         for (int i = 0; i < 16; i++)  img_rf[i]  = 8'($urandom);
         n = $urandom_range(4, 14);
         for (int i = 0; i < n; i++) begin
            sel = $urandom_range(0, 5);
            img_mem[2*i] = {ops[sel], 4'($urandom)};
            if (sel == 5) img_mem[2*i][7:4] = 4'($urandom_range(5, 14));
            case (sel)
               2, 3: img_mem[2*i+1] = 8'($urandom_range(128, 255));
               4: begin j = $urandom_range(i + 1, n); img_mem[2*i+1] = 8'(2 * j); end
               default: img_mem[2*i+1] = 8'($urandom);
            endcase
         end
         img_mem[2*n] = {4'hF, 4'($urandom)};
         run_prog($sformatf("random%0d", t), n * 8 + 30);
      end
   endtask

   initial begin
      test_reset();
      test_ldi_halt();
      test_ld();
      test_st();
      test_wrap();
      test_illegal();
      test_reset_mid_st();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
